// File: rtl/data_mem_if_if.sv
// Data-bus bundle between the memory-stage access unit (master) and the SRAM-like data port (slave).
interface data_mem_if_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_mem_if.sv
// M-stage data access unit: alignment checks, store formatting, req/addr_ok/data_ok handshake,
// load extension and pipeline stall, with optional access timeout.
module data_mem_if #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          validM,
  input  logic          flushM,
  input  logic          advanceM,
  input  logic [5:0]    opM,
  input  logic [31:0]   aluoutM,
  input  logic [31:0]   writedataM,
  output logic [31:0]   readdataM,
  output logic          adel_rdM,
  output logic          adesM,
  output logic          stall_memM,
  output logic          bus_errM,
  data_mem_if_if.master bus
);
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam bit         TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT) - 8'd1;

  logic        is_ld, is_st, is_half, is_word, misal, pend, start, to_hit;
  logic [1:0]  size_c;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;

  logic [1:0]  state_q, state_d;
  logic        discard_q, discard_d;
  logic        berr_q, berr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic        wr_q, ld_q, sx_q;
  logic [31:0] b_sh, h_sh, ext;

  always_comb begin
    is_ld   = opM inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    is_st   = opM inside {OP_SB, OP_SH, OP_SW};
    is_half = (opM[1:0] == 2'b01);
    is_word = (opM[1:0] == 2'b11);
    misal   = (is_half & aluoutM[0]) | (is_word & (aluoutM[1:0] != 2'b00));
    size_c  = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    wstrb_c = 4'b0000;
    wdata_c = 32'h0;
    if (is_st) begin
      case (size_c)
        2'd0: begin
          wstrb_c = 4'b0001 << aluoutM[1:0];
          wdata_c = {4{writedataM[7:0]}};
        end
        2'd1: begin
          wstrb_c = aluoutM[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{writedataM[15:0]}};
        end
        default: begin
          wstrb_c = 4'b1111;
          wdata_c = writedataM;
        end
      endcase
    end
  end

  assign adel_rdM = validM & is_ld & misal;
  assign adesM    = validM & is_st & misal;
  // A pending discard (late data_ok still owed) blocks new issue so it cannot be mistaken for ours.
  assign pend     = rst & validM & (is_ld | is_st) & ~misal & ~flushM;
  assign start    = pend & ~discard_q;
  assign to_hit   = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    berr_d    = berr_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (discard_q && bus.data_data_ok) discard_d = 1'b0;
        if (start) begin
          state_d = bus.data_addr_ok ? S_WAIT : S_REQ;
          cnt_d   = 8'd0;
        end
      end
      S_REQ: begin
        if (flushM) discard_d = 1'b1;
        if (bus.data_addr_ok) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end else if (to_hit) begin
          // Never accepted, so no response is owed.
          discard_d = 1'b0;
          if (discard_q | flushM) state_d = S_IDLE;
          else begin
            state_d = S_DONE;
            berr_d  = 1'b1;
            rdata_d = 32'h0;
          end
        end else cnt_d = cnt_q + 8'd1;
      end
      S_WAIT: begin
        if (bus.data_data_ok) begin
          if (discard_q | flushM) begin
            state_d   = S_IDLE;
            discard_d = 1'b0;
          end else begin
            state_d = S_DONE;
            rdata_d = bus.data_rdata;
          end
        end else begin
          if (flushM) discard_d = 1'b1;
          if (to_hit) begin
            discard_d = 1'b1;
            if (discard_q | flushM) state_d = S_IDLE;
            else begin
              state_d = S_DONE;
              berr_d  = 1'b1;
              rdata_d = 32'h0;
            end
          end else cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        if (discard_q && bus.data_data_ok) discard_d = 1'b0;
        if (advanceM | flushM) begin
          state_d = S_IDLE;
          berr_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      berr_q    <= 1'b0;
      cnt_q     <= 8'd0;
      rdata_q   <= 32'h0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      size_q    <= 2'd0;
      wstrb_q   <= 4'b0000;
      wr_q      <= 1'b0;
      ld_q      <= 1'b0;
      sx_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      berr_q    <= berr_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      if (state_q == S_IDLE && start) begin
        addr_q  <= aluoutM;
        wdata_q <= wdata_c;
        size_q  <= size_c;
        wstrb_q <= wstrb_c;
        wr_q    <= is_st;
        ld_q    <= is_ld;
        sx_q    <= ~opM[2];
      end
    end
  end

  // The first request cycle is driven straight from M; later cycles replay the registered copy.
  always_comb begin
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 2'd0;
    bus.data_addr  = 32'h0;
    bus.data_wstrb = 4'b0000;
    bus.data_wdata = 32'h0;
    if (state_q == S_IDLE && start) begin
      bus.data_req   = 1'b1;
      bus.data_wr    = is_st;
      bus.data_size  = size_c;
      bus.data_addr  = aluoutM;
      bus.data_wstrb = wstrb_c;
      bus.data_wdata = wdata_c;
    end else if (state_q == S_REQ) begin
      bus.data_req   = 1'b1;
      bus.data_wr    = wr_q;
      bus.data_size  = size_q;
      bus.data_addr  = addr_q;
      bus.data_wstrb = wstrb_q;
      bus.data_wdata = wdata_q;
    end
  end

  always_comb begin
    b_sh = rdata_q >> {addr_q[1:0], 3'b000};
    h_sh = rdata_q >> {addr_q[1], 4'b0000};
    case (size_q)
      2'd0:    ext = sx_q ? {{24{b_sh[7]}}, b_sh[7:0]} : {24'h0, b_sh[7:0]};
      2'd1:    ext = sx_q ? {{16{h_sh[15]}}, h_sh[15:0]} : {16'h0, h_sh[15:0]};
      default: ext = rdata_q;
    endcase
    readdataM = (state_q == S_DONE && ld_q) ? ext : 32'h0;
  end

  assign stall_memM = (state_q == S_REQ) | (state_q == S_WAIT) | ((state_q == S_IDLE) & pend);
  assign bus_errM   = berr_q;
endmodule
